// File: rtl/elastic_buffer.sv
// ---------------------------------------------------------------------------
// elastic_buffer
//
// DEPTH-entry first-word-fall-through elastic buffer placed between pipeline
// stages. It decouples producer and consumer, absorbs backpressure, reports
// its fill level and supports a synchronous flush.
//
// Parameters
//   DATA_WIDTH  payload width in bits (>= 1)
//   DEPTH       number of storage entries (power of two, >= 2)
//   CNT_W       width of count_o, derived from DEPTH (not overridable)
//
// Ports
//   clk_i      in   clock, all state updates on the rising edge
//   reset_n_i  in   asynchronous active-low reset
//   flush_i    in   synchronous flush, discards every stored entry
//   s_valid_i  in   upstream payload valid
//   s_ready_o  out  buffer can accept s_data_i this cycle
//   s_data_i   in   upstream payload
//   m_valid_o  out  m_data_o holds the oldest stored entry
//   m_ready_i  in   downstream accepts m_data_o this cycle
//   m_data_o   out  oldest stored entry, zero while m_valid_o is low
//   count_o    out  number of stored entries, 0..DEPTH
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. valid, once offered, is not required
// to be held by this block; ready never depends combinationally on the
// other side's valid/ready, so s_ready_o and m_valid_o come from registered
// occupancy only.
// ---------------------------------------------------------------------------
module elastic_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Occupancy class decoded from the registered count; a convenient
    // observation point for checkers.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    occ_e                  occ_state;
    logic                  push;
    logic                  pop;

    always_comb begin
        occ_state = OCC_PARTIAL;
        if (count == '0) begin
            occ_state = OCC_EMPTY;
        end else if (count == CNT_W'(DEPTH)) begin
            occ_state = OCC_FULL;
        end
    end

    assign s_ready_o = (occ_state != OCC_FULL);
    assign m_valid_o = (occ_state != OCC_EMPTY);
    assign push      = s_valid_i & s_ready_o;
    assign pop       = m_valid_o & m_ready_i;
    assign count_o   = count;

    // Storage is never reset, so stale or X contents are masked while empty.
    assign m_data_o  = m_valid_o ? mem[rd_ptr] : '0;

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on
    // plain increment. Flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

endmodule

// File: tb/tb_elastic_buffer.sv
// ---------------------------------------------------------------------------
// tb_elastic_buffer
//
// Three buffer instances (DEPTH/DATA_WIDTH = 4/32, 2/1, 16/32) run the same
// directed sequences followed by randomized valid/ready/flush traffic.
// Each instance has a driver that tracks the expected occupancy as a plain
// integer and queues every word it expects to be accepted, and a monitor
// that, on the falling edge, compares flags, count and head-of-queue data.
// ---------------------------------------------------------------------------
module tb_elastic_buffer;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int CFG_ID = g;
        localparam int D  = (g == 0) ? 4 : ((g == 1) ? 2 : 16);
        localparam int W  = (g == 1) ? 1 : 32;
        localparam int CW = $clog2(D + 1);

        logic          rst_n;
        logic          flush;
        logic          s_valid;
        logic          s_ready;
        logic [W-1:0]  s_data;
        logic          m_valid;
        logic          m_ready;
        logic [W-1:0]  m_data;
        logic [CW-1:0] count;

        logic [W-1:0]  exp_q[$];
        int            occ      = 0;  // expected occupancy after the next edge
        int            cur_occ  = 0;  // expected occupancy during this cycle
        bit            checking = 1'b0;

        elastic_buffer #(
            .DATA_WIDTH(W),
            .DEPTH     (D)
        ) dut (
            .clk_i    (clk),
            .reset_n_i(rst_n),
            .flush_i  (flush),
            .s_valid_i(s_valid),
            .s_ready_o(s_ready),
            .s_data_i (s_data),
            .m_valid_o(m_valid),
            .m_ready_i(m_ready),
            .m_data_o (m_data),
            .count_o  (count)
        );

        task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
            total++;
            if (act !== req) begin
                bad++;
                $display("FAIL %s cfg=%0d t=%0t got=%0h want=%0h", name, CFG_ID, $time, act, req);
            end
        endtask

        task automatic check_reset_outputs(input string tag);
            check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
            check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
            check({tag, "_m_data"},  32'(m_data),  32'd0);
            check({tag, "_count"},   32'(count),   32'd0);
        endtask

        // Drive one cycle of stimulus (called just after a rising edge) and
        // advance the occupancy model to what the next edge should produce.
        task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
            logic push;
            logic pop;
            s_valid = sv;
            s_data  = sv ? W'(sd) : 'x;
            m_ready = mr;
            flush   = fl;
            cur_occ = occ;
            push    = sv && !fl && (occ < D);
            pop     = mr && (occ > 0);
            if (fl) begin
                occ = 0;
                exp_q.delete();
            end else begin
                if (push) exp_q.push_back(W'(sd));
                occ = occ + int'(push) - int'(pop);
            end
            @(posedge clk);
            #1;
        endtask

        task automatic fill(input int n, input int base);
            for (int i = 0; i < n; i++) step(1'b1, 32'(base + i), 1'b0, 1'b0);
        endtask

        task automatic drain();
            for (int i = 0; i < D + 1; i++) begin
                if (occ > 0) step(1'b0, 32'd0, 1'b1, 1'b0);
            end
            step(1'b0, 32'd0, 1'b1, 1'b0);
        endtask

        task automatic random_phase(input int n, input int pv, input int pr, input int pf);
            for (int i = 0; i < n; i++) begin
                step($urandom_range(99) < pv, $urandom, $urandom_range(99) < pr,
                     $urandom_range(999) < pf);
            end
        endtask

        // Asynchronous reset in the middle of a cycle with data stored.
        task automatic mid_reset();
            fill(3, 'h30);
            step(1'b0, 32'd0, 1'b0, 1'b0);
            checking = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            occ     = 0;
            cur_occ = 0;
            exp_q.delete();
            s_valid = 1'b0;
            m_ready = 1'b0;
            flush   = 1'b0;
            @(posedge clk);
            #1;
            rst_n    = 1'b1;
            checking = 1'b1;
        endtask

        // Monitor: mid-cycle comparison of every output against the model.
        initial begin
            forever begin
                @(negedge clk);
                if (checking && rst_n) begin
                    check("count",   32'(count),   32'(cur_occ));
                    check("s_ready", 32'(s_ready), 32'(cur_occ < D));
                    check("m_valid", 32'(m_valid), 32'(cur_occ > 0));
                    if (!m_valid) begin
                        check("m_data_idle", 32'(m_data), 32'd0);
                    end else if (!flush) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_valid", 32'(m_valid), 32'd0);
                        end else begin
                            check("m_data", 32'(m_data), 32'(exp_q[0]));
                            if (m_ready) void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end

        // Driver.
        initial begin
            rst_n   = 1'b0;
            flush   = 1'b0;
            s_valid = 1'b0;
            s_data  = '0;
            m_ready = 1'b0;
            #2;
            check_reset_outputs("reset");
            @(posedge clk);
            #1;
            rst_n    = 1'b1;
            checking = 1'b1;

            // Fill past capacity with consumer stalled, then drain in order.
            fill(D + 1, 'hA0);
            drain();

            // Single word into an empty buffer: visible only after its edge.
            step(1'b1, 32'h5, 1'b0, 1'b0);
            step(1'b0, 32'd0, 1'b0, 1'b0);
            drain();

            // Streaming push+pop at a steady level; pointers wrap repeatedly.
            fill(2, 'hB0);
            for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
            drain();

            // Full buffer: pop and offered push together, push must wait.
            fill(D, 'h40);
            step(1'b1, 32'h55, 1'b1, 1'b0);
            step(1'b1, 32'h55, 1'b0, 1'b0);
            step(1'b0, 32'd0, 1'b0, 1'b0);
            drain();

            // Flush with a concurrent push: the pushed word must vanish.
            fill(3, 'h60);
            step(1'b1, 32'hFF, 1'b0, 1'b1);
            step(1'b0, 32'd0, 1'b0, 1'b0);
            step(1'b0, 32'd0, 1'b1, 1'b0);

            mid_reset();
            step(1'b0, 32'd0, 1'b1, 1'b0);

            random_phase(300, 50, 50, 5);
            random_phase(300, 85, 25, 5);
            random_phase(300, 25, 85, 5);
            random_phase(300, 60, 60, 30);
            drain();

            checking = 1'b0;
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && done_cnt < NCFG; c++) @(posedge clk);
        if (done_cnt < NCFG) begin
            total++;
            bad++;
            $display("FAIL timeout done=%0d want=%0d", done_cnt, NCFG);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
